// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding instruction fetcher feeding a DEPTH-entry {pc, instr} prefetch queue.
// Define FETCH_BYPASS_EN to forward a live ack straight to out_* when the queue is empty.
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;
  state_t        state;
  logic [63:0]   fetch_pc, req_addr;
  logic [63:0]   pc_q  [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          live_ack, has_head, push, pop;
  assign imem_req  = state != IDLE;
  assign imem_addr = req_addr;
  assign live_ack  = state == BUSY && imem_ack && !redirect;
  assign has_head  = count != '0;
  assign pop       = has_head && out_ready && !redirect;
`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = live_ack && !has_head;
  assign out_valid = has_head || bypass;
  assign out_instr = has_head ? ins_q[rd_ptr] : bypass ? imem_data : '0;
  assign out_pc    = has_head ? pc_q[rd_ptr] : bypass ? req_addr : '0;
  assign push      = live_ack && !(bypass && out_ready);
`else
  assign out_valid = has_head;
  assign out_instr = has_head ? ins_q[rd_ptr] : '0;
  assign out_pc    = has_head ? pc_q[rd_ptr] : '0;
  assign push      = live_ack;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE:    if (!redirect && count < (AW+1)'(DEPTH)) begin
                   state    <= BUSY;
                   req_addr <= fetch_pc;
                 end
        BUSY:    state <= imem_ack ? IDLE : redirect ? DISCARD : BUSY;
        DISCARD: state <= imem_ack ? IDLE : DISCARD;
        default: state <= IDLE;
      endcase
      // a redirect flushes the queue and wins over any same-edge pop
      if (redirect) begin
        fetch_pc <= {redirect_pc[63:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (live_ack) fetch_pc <= fetch_pc + 64'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[wr_ptr]  <= req_addr;
      ins_q[wr_ptr] <= imem_data;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random and directed stimulus against a queue-based reference of the fetch unit.
module tb_instruction_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0;
  logic        clock, reset, imem_req, imem_ack, redirect, out_valid, out_ready;
  logic [63:0] imem_addr, redirect_pc, out_pc;
  logic [31:0] imem_data, out_instr;
  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc));
  initial clock = 0;
  always #5 clock = ~clock;
  typedef struct {logic [63:0] pc; logic [31:0] ins;} ent_t;
  ent_t        q[$];
  logic [63:0] popped[$];
  logic [63:0] exp_pc, out_addr;
  logic [31:0] fix_val;
  bit          outstanding, stale, issued, last_ack, fix_data;
  int          lat, lat_cfg, pushes;
  int          compared, mismatched;
  task automatic cycle(input bit rd, input logic [63:0] rpc, input bit rdy);
    bit ack, live, was_empty;
    @(negedge clock);
    issued = 0;
    compared++;
    if (out_valid !== (q.size() != 0)) begin
      mismatched++;
      $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      compared++;
      if (out_pc !== q[0].pc || out_instr !== q[0].ins) begin
        mismatched++;
        $display("FAIL head: got %h/%h expected %h/%h", out_pc, out_instr, q[0].pc, q[0].ins);
      end
    end
    if (outstanding) begin
      compared++;
      if (imem_req !== 1'b1 || imem_addr !== out_addr) begin
        mismatched++;
        $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, out_addr);
      end
    end else if (imem_req === 1'b1) begin
      issued = 1;
      outstanding = 1;
      stale = 0;
      out_addr = imem_addr;
      lat = lat_cfg < 0 ? int'($urandom_range(3, 0)) : lat_cfg;
      compared++;
      if (imem_addr !== exp_pc) begin
        mismatched++;
        $display("FAIL req_addr: got %h expected %h", imem_addr, exp_pc);
      end
    end
    ack = outstanding && lat == 0;
    if (outstanding && !ack) lat--;
    imem_ack = ack;
    imem_data = fix_data ? fix_val : $urandom;
    redirect = rd;
    redirect_pc = rpc;
    out_ready = rdy;
    last_ack = ack;
    live = ack && !stale && !rd;
    was_empty = q.size() == 0;
    #1;
    if (live && was_empty) begin
      compared++;
`ifdef FETCH_BYPASS_EN
      if (out_valid !== 1'b1 || out_instr !== imem_data || out_pc !== out_addr) begin
        mismatched++;
        $display("FAIL bypass: got %b %h/%h expected 1 %h/%h", out_valid, out_pc, out_instr, out_addr, imem_data);
      end
`else
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL latency: got out_valid=%b expected 0", out_valid);
      end
`endif
    end
    @(posedge clock);
    if (!rd && rdy && !was_empty) begin
      popped.push_back(q[0].pc);
      void'(q.pop_front());
    end
    if (live) begin
      exp_pc += 64'd4;
      pushes++;
`ifdef FETCH_BYPASS_EN
      if (was_empty && rdy) popped.push_back(out_addr);
      else q.push_back('{out_addr, imem_data});
`else
      q.push_back('{out_addr, imem_data});
`endif
    end
    if (ack) outstanding = 0;
    else if (rd && outstanding) stale = 1;
    if (rd) begin
      q.delete();
      exp_pc = {rpc[63:2], 2'b00};
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 0;
    #1;
    compared += 4;
    if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (out_instr !== 32'h0) begin mismatched++; $display("FAIL rst_instr: got %h expected 0", out_instr); end
    if (out_pc !== 64'h0) begin mismatched++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
    q.delete();
    popped.delete();
    outstanding = 0;
    stale = 0;
    pushes = 0;
    exp_pc = RST_PC;
    fix_data = 0;
    @(negedge clock);
    reset = 1;
    imem_ack = 1;
    imem_data = $urandom;
    redirect = 0;
    out_ready = 0;
  endtask
  task automatic wait_issue(input bit rdy, input string name);
    int n = 0;
    do begin cycle(0, 64'h0, rdy); n++; end while (!issued && n < 40);
    if (!issued) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no request expected one", name);
    end
  endtask
  task automatic test_reset();
    do_reset();
    lat_cfg = 0;
    repeat (6) cycle(0, 64'h0, 0);
  endtask
  task automatic test_reset_abandon();
    do_reset();
    lat_cfg = 6;
    wait_issue(0, "abandon");
    repeat (2) cycle(0, 64'h0, 0);
    do_reset();
    lat_cfg = 0;
    repeat (8) cycle(0, 64'h0, 0);
  endtask
  task automatic test_stream();
    int n = 0;
    do_reset();
    lat_cfg = 0;
    while (popped.size() < 4 && n < 60) begin cycle(0, 64'h0, 1); n++; end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (i >= popped.size() || popped[i] !== 64'(4 * i)) begin
        mismatched++;
        $display("FAIL stream[%0d]: got %h expected %h", i, i < popped.size() ? popped[i] : 64'hx, 64'(4 * i));
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    lat_cfg = 0;
    repeat (30) cycle(0, 64'h0, 0);
    #1;
    compared += 2;
    if (pushes != DEPTH) begin mismatched++; $display("FAIL full_pushes: got %0d expected %0d", pushes, DEPTH); end
    if (imem_req !== 1'b0) begin mismatched++; $display("FAIL full_req: got %b expected 0", imem_req); end
    wait_issue(1, "resume");
    compared++;
    if (out_addr !== 64'h10) begin mismatched++; $display("FAIL resume_addr: got %h expected 10", out_addr); end
  endtask
  task automatic test_redirect_busy();
    int n = 0;
    do_reset();
    lat_cfg = 4;
    do begin cycle(0, 64'h0, 0); n++; end while (!(issued && out_addr == 64'h8) && n < 60);
    cycle(1, 64'h100, 0);
    wait_issue(0, "redir_busy");
    compared += 2;
    if (out_addr !== 64'h100) begin mismatched++; $display("FAIL redir_busy_addr: got %h expected 100", out_addr); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL redir_busy_empty: got %b expected 0", out_valid); end
  endtask
  task automatic test_redirect_ack();
    do_reset();
    lat_cfg = 2;
    wait_issue(0, "redir_ack0");
    cycle(0, 64'h0, 0);
    cycle(1, 64'h103, 0);
    compared++;
    if (!last_ack) begin mismatched++; $display("FAIL redir_ack_align: got ack=0 expected 1"); end
    wait_issue(0, "redir_ack");
    compared += 2;
    if (out_addr !== 64'h100) begin mismatched++; $display("FAIL redir_ack_addr: got %h expected 100", out_addr); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL redir_ack_empty: got %b expected 0", out_valid); end
  endtask
  task automatic test_wrap();
    do_reset();
    lat_cfg = 1;
    wait_issue(1, "wrap0");
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    wait_issue(1, "wrap1");
    compared++;
    if (out_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin mismatched++; $display("FAIL wrap_top: got %h expected fffffffffffffffc", out_addr); end
    wait_issue(1, "wrap2");
    compared++;
    if (out_addr !== 64'h0) begin mismatched++; $display("FAIL wrap_zero: got %h expected 0", out_addr); end
  endtask
  task automatic test_latency();
    int n = 0;
    do_reset();
    lat_cfg = 1;
    fix_data = 1;
    fix_val = 32'hF800_0020;
    do begin cycle(0, 64'h0, 0); n++; end while (!last_ack && n < 20);
    @(negedge clock);
    compared++;
    if (out_valid !== 1'b1 || out_instr !== 32'hF800_0020 || out_pc !== 64'h0) begin
      mismatched++;
      $display("FAIL latency_next: got %b %h/%h expected 1 0/f8000020", out_valid, out_pc, out_instr);
    end
    fix_data = 0;
  endtask
  task automatic test_random();
    logic [63:0] rpc;
    do_reset();
    lat_cfg = -1;
    for (int i = 0; i < 800; i++) begin
      rpc = $urandom_range(7, 0) == 0 ? {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom)} : {$urandom, $urandom};
      cycle($urandom_range(99, 0) < 8, rpc, $urandom_range(99, 0) < 60);
    end
  endtask
  initial begin
    reset = 0;
    imem_ack = 0;
    imem_data = 0;
    redirect = 0;
    redirect_pc = 0;
    out_ready = 0;
    compared = 0;
    mismatched = 0;
    test_reset();
    test_reset_abandon();
    test_stream();
    test_backpressure();
    test_redirect_busy();
    test_redirect_ack();
    test_wrap();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset.
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-low; reset==0 clears all state immediately.
REQ-005 imem_req  output  1  SHALL be the instruction-memory request, held high until imem_ack.
REQ-006 imem_addr  output  64  SHALL be the requested byte address, stable while imem_req==1.
REQ-007 imem_ack  input  1  SHALL be a one-cycle acknowledge qualifying imem_data.
REQ-008 imem_data  input  32  SHALL be the returned instruction word.
REQ-009 redirect  input  1  SHALL request a pipeline flush and a PC change (taken branch).
REQ-010 redirect_pc  input  64  SHALL be the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-011 out_valid  output  1  SHALL mark a valid instruction for the IF/ID register.
REQ-012 out_ready  input  1  SHALL be the decode-stage accept; a transfer occurs when out_valid & out_ready.
REQ-013 out_instr  output  32  SHALL be the instruction at the queue head.
REQ-014 out_pc  output  64  SHALL be the byte address of out_instr.

Function
REQ-015 The unit SHALL hold a fetch PC register and a DEPTH-entry FIFO of {pc, instr} pairs.
REQ-016 The FSM SHALL have states IDLE (nothing outstanding), BUSY (live request outstanding), and DISCARD (stale request outstanding).
REQ-017 IDLE->BUSY SHALL occur when count+1 <= DEPTH and redirect==0; req_addr<=fetch_pc and imem_req=1 from the next cycle.
REQ-018 At most one request SHALL be outstanding; imem_req SHALL be 1 exactly in BUSY and DISCARD; imem_addr SHALL equal req_addr.
REQ-019 In BUSY, an imem_ack with redirect==0 SHALL push {req_addr, imem_data}, set fetch_pc<=fetch_pc+4 (mod 2^64), and go to IDLE.
REQ-020 In BUSY, redirect==1 without ack SHALL go to DISCARD; redirect with ack in the same cycle SHALL drop the data and go to IDLE.
REQ-021 In DISCARD, imem_ack SHALL drop data and go to IDLE; further redirects SHALL only update fetch_pc.
REQ-022 Any redirect SHALL empty the FIFO and set fetch_pc<=redirect_pc in the same edge; a simultaneous pop SHALL be ignored.
REQ-023 out_valid SHALL be 1 whenever FIFO count>0; out_instr and out_pc SHALL show the head entry; pop on transfer.
REQ-024 A push and pop in the same cycle SHALL leave count unchanged; issue SHALL be blocked at count==DEPTH, so a push never overflows.
REQ-025 Without bypass, imem_ack at edge N SHALL yield out_valid at cycle N+1 (one-cycle latency).
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-027 On reset==0: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, FIFO empty, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-028 Reset asserted while BUSY SHALL abandon the request; a late imem_ack after reset release, arriving in IDLE, SHALL be ignored.

Configuration
REQ-029 Macro FETCH_BYPASS_EN defined: when the FIFO is empty and a live ack arrives, out_valid/out_instr/out_pc SHALL reflect {req_addr, imem_data} in the same cycle, and if out_ready==1 the word SHALL be consumed without a FIFO write.
REQ-030 Macro FETCH_BYPASS_EN undefined: no combinational path from imem_* to out_*; the latency in REQ-025 applies.

Verification
REQ-031 Reset release, RESET_PC=0, imem acks with 1-cycle latency, out_ready=1 -> out_pc sequence 0,4,8,12; no gaps after the first.
REQ-032 out_ready=0, DEPTH=4 -> exactly 4 pushes; imem_req stays 0 with count==4; raising out_ready resumes at pc 16.
REQ-033 Redirect to 0x100 while BUSY at 0x8 with ack 3 cycles later -> data for 0x8 dropped, FIFO empty, next request address 0x100.
REQ-034 Redirect and ack in the same cycle -> no push, FIFO empty, next imem_addr = redirect_pc; redirect_pc=0x103 fetches 0x100.
REQ-035 fetch_pc=64'hFFFF_FFFF_FFFF_FFFC acked -> next request address 0x0.
REQ-036 With FETCH_BYPASS_EN, empty FIFO, ack with imem_data=32'hF8000020 -> out_valid=1 in the same cycle; without it, out_valid=1 one cycle later.
